// File: rtl/risc_pkg.sv
// Shared core types: memory access sizes and load/store unit state.
// Also provides the access-size to byte-count helper.
package risc_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2
    } lsu_state_t;

    function automatic logic [2:0] size_bytes(mem_size_t s);
        logic [2:0] n;
        unique case (s)
            BYTE:      n = 3'd1;
            HALF_WORD: n = 3'd2;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of raw little-endian load bytes to 32 bits.
module lsu_load_extend
    import risc_pkg::*;
(
    input  logic [31:0] raw_i,
    input  mem_size_t   size_i,
    input  logic        zero_extend_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = raw_i;
        unique case (size_i)
            BYTE:
                data_o = {{24{raw_i[7] & ~zero_extend_i}}, raw_i[7:0]};
            HALF_WORD:
                data_o = {{16{raw_i[15] & ~zero_extend_i}}, raw_i[15:0]};
            default:
                data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: range check, misalignment trap or byte split.
// Split mode is enabled by defining LSU_MISALIGN_SPLIT_EN.
module load_store_unit
    import risc_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr_en,
    input  mem_size_t   req_size,
    input  logic        req_zero_extend,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wr_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_rd_data,
    output logic        rsp_fault,
    output logic        rsp_misaligned,
    output logic        dmem_req,
    output logic        dmem_wr_en,
    output logic        dmem_zero_extend,
    output mem_size_t   dmem_data_size,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wr_data,
    input  logic [31:0] dmem_rd_data
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    mem_size_t   size_q;
    logic        wr_en_q, zext_q, fault_q, mis_q;

    logic        accept;
    logic [32:0] last_byte;
    logic        req_fault, req_mis;
    logic        split_last, done, rd_ok;
    logic [31:0] ext_raw, ext_data;

    logic        rsp_valid_q, rsp_fault_q, rsp_mis_q;
    logic        rsp_valid_d, rsp_fault_d, rsp_mis_d;
    logic [31:0] rsp_rd_data_q, rsp_rd_data_d;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // 33-bit sum so that a 32-bit address wrap counts as out of range
    assign last_byte = {1'b0, req_addr}
                     + {30'd0, size_bytes(req_size)} - 33'd1;
    assign req_fault = last_byte >= (33'd1 << ADDR_WIDTH);
    assign req_mis   = (req_size == HALF_WORD && req_addr[0])
                     || (req_size == WORD && req_addr[1:0] != 2'b00);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, assembled;
    logic [2:0]  nbytes;

    assign nbytes     = size_bytes(size_q) - 3'd1;
    assign split_last = (cnt_q == nbytes[1:0]);

    always_comb begin
        assembled = buf_q;
        assembled[{cnt_q, 3'b000} +: 8] = dmem_rd_data[7:0];
    end

    assign ext_raw = (state_q == SPLIT) ? assembled : dmem_rd_data;

    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = 2'd0;
        else if (state_q == SPLIT)
            cnt_d = cnt_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
            buf_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            if (accept)
                buf_q <= 32'd0;
            else if (state_q == SPLIT)
                buf_q <= assembled;
        end
    end
`else
    assign split_last = 1'b1;
    assign ext_raw    = dmem_rd_data;
`endif

    lsu_load_extend u_ext (
        .raw_i         (ext_raw),
        .size_i        (size_q),
        .zero_extend_i (zext_q),
        .data_o        (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_d = (req_mis && !req_fault) ? SPLIT : ACCESS;
`else
                    state_d = ACCESS;
`endif
                end
            end
            ACCESS:  state_d = IDLE;
            SPLIT:   if (split_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem_req         = 1'b0;
        dmem_wr_en       = 1'b0;
        dmem_zero_extend = 1'b0;
        dmem_data_size   = BYTE;
        dmem_addr        = 32'd0;
        dmem_wr_data     = 32'd0;
        unique case (state_q)
            ACCESS: begin
                if (!fault_q && !mis_q) begin
                    dmem_req         = 1'b1;
                    dmem_wr_en       = wr_en_q;
                    dmem_zero_extend = zext_q;
                    dmem_data_size   = size_q;
                    dmem_addr        = addr_q;
                    dmem_wr_data     = wdata_q;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
                dmem_req         = 1'b1;
                dmem_wr_en       = wr_en_q;
                dmem_zero_extend = 1'b1;
                dmem_data_size   = BYTE;
                dmem_addr        = addr_q + {30'd0, cnt_q};
                dmem_wr_data     = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= BYTE;
            wr_en_q <= 1'b0;
            zext_q  <= 1'b0;
            fault_q <= 1'b0;
            mis_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wr_data;
            size_q  <= req_size;
            wr_en_q <= req_wr_en;
            zext_q  <= req_zero_extend;
            fault_q <= req_fault;
            mis_q   <= req_mis;
        end
    end

    assign done  = (state_q == ACCESS) || (state_q == SPLIT && split_last);
    assign rd_ok = !wr_en_q && !fault_q && (state_q == SPLIT || !mis_q);

    always_comb begin
        rsp_valid_d   = done;
        rsp_fault_d   = (state_q == ACCESS) && fault_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        rsp_mis_d     = 1'b0;
`else
        rsp_mis_d     = (state_q == ACCESS) && mis_q && !fault_q;
`endif
        rsp_rd_data_d = (done && rd_ok) ? ext_data : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_fault_q   <= 1'b0;
            rsp_mis_q     <= 1'b0;
            rsp_rd_data_q <= 32'd0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_mis_q     <= rsp_mis_d;
            rsp_rd_data_q <= rsp_rd_data_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_fault      = rsp_fault_q;
    assign rsp_misaligned = rsp_mis_q;
    assign rsp_rd_data    = rsp_rd_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr_en, req_zero_extend;
    mem_size_t   req_size;
    logic [31:0] req_addr, req_wr_data;
    logic        rsp_valid, rsp_fault, rsp_misaligned;
    logic [31:0] rsp_rd_data;
    logic        dmem_req, dmem_wr_en, dmem_zero_extend;
    mem_size_t   dmem_data_size;
    logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;

    logic [7:0]  mem [0:65535];
    int          n_chk = 0;
    int          n_fail = 0;

    load_store_unit #(.ADDR_WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_wr_en        (req_wr_en),
        .req_size         (req_size),
        .req_zero_extend  (req_zero_extend),
        .req_addr         (req_addr),
        .req_wr_data      (req_wr_data),
        .rsp_valid        (rsp_valid),
        .rsp_rd_data      (rsp_rd_data),
        .rsp_fault        (rsp_fault),
        .rsp_misaligned   (rsp_misaligned),
        .dmem_req         (dmem_req),
        .dmem_wr_en       (dmem_wr_en),
        .dmem_zero_extend (dmem_zero_extend),
        .dmem_data_size   (dmem_data_size),
        .dmem_addr        (dmem_addr),
        .dmem_wr_data     (dmem_wr_data),
        .dmem_rd_data     (dmem_rd_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [15:0] a;
        a = dmem_addr[15:0];
        dmem_rd_data = {mem[a + 16'd3], mem[a + 16'd2],
                        mem[a + 16'd1], mem[a]};
        if (dmem_data_size == BYTE)
            dmem_rd_data[31:8] = 24'd0;
        else if (dmem_data_size == HALF_WORD)
            dmem_rd_data[31:16] = 16'd0;
    end

    always @(posedge clk) begin
        if (dmem_req && dmem_wr_en) begin
            mem[dmem_addr[15:0]] = dmem_wr_data[7:0];
            if (dmem_data_size != BYTE)
                mem[dmem_addr[15:0] + 16'd1] = dmem_wr_data[15:8];
            if (dmem_data_size == WORD) begin
                mem[dmem_addr[15:0] + 16'd2] = dmem_wr_data[23:16];
                mem[dmem_addr[15:0] + 16'd3] = dmem_wr_data[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic wr,
                        input mem_size_t sz, input logic zx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_req, input logic [31:0] exp_rd,
                        input logic exp_flt, input logic exp_mis);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wr_en = wr; req_size = sz;
        req_zero_extend = zx; req_addr = a; req_wr_data = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, ".c1_req"}, 32'(dmem_req), 32'(exp_req));
        chk({tag, ".c1_rdy"}, 32'(req_ready), 32'd0);
        chk({tag, ".c1_rspv"}, 32'(rsp_valid), 32'd0);
        if (exp_req) begin
            chk({tag, ".c1_addr"}, dmem_addr, a);
            chk({tag, ".c1_size"}, 32'(dmem_data_size), 32'(sz));
            chk({tag, ".c1_we"}, 32'(dmem_wr_en), 32'(wr));
        end else begin
            chk({tag, ".c1_addr0"}, dmem_addr, 32'd0);
        end
        @(posedge clk); #1;
        chk({tag, ".c2_rspv"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".c2_rd"}, rsp_rd_data, exp_rd);
        chk({tag, ".c2_flt"}, 32'(rsp_fault), 32'(exp_flt));
        chk({tag, ".c2_mis"}, 32'(rsp_misaligned), 32'(exp_mis));
        chk({tag, ".c2_rdy"}, 32'(req_ready), 32'd1);
        chk({tag, ".c2_req"}, 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".c3_rspv"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".c3_rd"}, rsp_rd_data, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_wr_en = 1'b0;
        req_size = BYTE; req_zero_extend = 1'b0;
        req_addr = 32'd0; req_wr_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.rspv", 32'(rsp_valid), 32'd0);
        chk("rst.rd", rsp_rd_data, 32'd0);
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.addr", dmem_addr, 32'd0);
        @(negedge clk); rst = 1'b0;

        xfer("sw", 1'b1, WORD, 1'b0, 32'h0100, 32'hDEADBEEF,
             1'b1, 32'd0, 1'b0, 1'b0);
        chk("sw.mem", {mem[16'h0103], mem[16'h0102],
                       mem[16'h0101], mem[16'h0100]}, 32'hDEADBEEF);
        xfer("lw", 1'b0, WORD, 1'b0, 32'h0100, 32'h0,
             1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        xfer("lb", 1'b0, BYTE, 1'b0, 32'h0100, 32'h0,
             1'b1, 32'hFFFFFFEF, 1'b0, 1'b0);
        xfer("lbu", 1'b0, BYTE, 1'b1, 32'h0100, 32'h0,
             1'b1, 32'h000000EF, 1'b0, 1'b0);
        xfer("lh", 1'b0, HALF_WORD, 1'b0, 32'h0102, 32'h0,
             1'b1, 32'hFFFFDEAD, 1'b0, 1'b0);
        xfer("lhu", 1'b0, HALF_WORD, 1'b1, 32'h0102, 32'h0,
             1'b1, 32'h0000DEAD, 1'b0, 1'b0);
        xfer("sb", 1'b1, BYTE, 1'b0, 32'hFFFF, 32'h000000A5,
             1'b1, 32'd0, 1'b0, 1'b0);
        chk("sb.mem", 32'(mem[16'hFFFF]), 32'h000000A5);
        xfer("lbtop", 1'b0, BYTE, 1'b0, 32'hFFFF, 32'h0,
             1'b1, 32'hFFFFFFA5, 1'b0, 1'b0);
        xfer("lwflt", 1'b0, WORD, 1'b0, 32'hFFFE, 32'h0,
             1'b0, 32'd0, 1'b1, 1'b0);
        xfer("lhflt", 1'b0, HALF_WORD, 1'b0, 32'hFFFF, 32'h0,
             1'b0, 32'd0, 1'b1, 1'b0);
        xfer("lwwrap", 1'b0, WORD, 1'b0, 32'hFFFFFFFC, 32'h0,
             1'b0, 32'd0, 1'b1, 1'b0);
        xfer("swflt", 1'b1, WORD, 1'b0, 32'h00010000, 32'h12345678,
             1'b0, 32'd0, 1'b1, 1'b0);

`ifdef LSU_MISALIGN_SPLIT_EN
        // word store to 0x0201 splits into four byte writes
        @(negedge clk);
        req_valid = 1'b1; req_wr_en = 1'b1; req_size = WORD;
        req_zero_extend = 1'b0; req_addr = 32'h0201;
        req_wr_data = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] wv;
            wv = 32'h11223344;
            chk("ssplit.req", 32'(dmem_req), 32'd1);
            chk("ssplit.addr", dmem_addr, 32'h0201 + 32'(i));
            chk("ssplit.data", dmem_wr_data, {24'd0, wv[8*i +: 8]});
            chk("ssplit.size", 32'(dmem_data_size), 32'(BYTE));
            chk("ssplit.rspv", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("ssplit.rspv1", 32'(rsp_valid), 32'd1);
        chk("ssplit.mis", 32'(rsp_misaligned), 32'd0);
        chk("ssplit.mem", {mem[16'h0204], mem[16'h0203],
                           mem[16'h0202], mem[16'h0201]}, 32'h11223344);

        @(negedge clk);
        req_valid = 1'b1; req_wr_en = 1'b0; req_size = HALF_WORD;
        req_zero_extend = 1'b0; req_addr = 32'h0203;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("lsplit.c1", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        chk("lsplit.c2", 32'(dmem_addr), 32'h0204);
        chk("lsplit.c2v", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("lsplit.rspv", 32'(rsp_valid), 32'd1);
        chk("lsplit.rd", rsp_rd_data, 32'h00001122);

        // reset during the second byte of a split store
        @(negedge clk);
        req_valid = 1'b1; req_wr_en = 1'b1; req_size = WORD;
        req_addr = 32'h0301; req_wr_data = 32'hAABBCCDD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rsplit.c2addr", dmem_addr, 32'h0302);
        rst = 1'b1;
        #1;
        chk("rsplit.req", 32'(dmem_req), 32'd0);
        chk("rsplit.addr", dmem_addr, 32'd0);
        chk("rsplit.rdy", 32'(req_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rsplit.norsp", 32'(rsp_valid), 32'd0);
        end
        chk("rsplit.b0", 32'(mem[16'h0301]), 32'h000000DD);
        chk("rsplit.b1", 32'(mem[16'h0302]), 32'h00000000);
`else
        xfer("lhmis", 1'b0, HALF_WORD, 1'b0, 32'h0101, 32'h0,
             1'b0, 32'd0, 1'b0, 1'b1);
        xfer("swmis", 1'b1, WORD, 1'b0, 32'h0202, 32'hCAFEF00D,
             1'b0, 32'd0, 1'b0, 1'b1);
        chk("swmis.mem", 32'(mem[16'h0202]), 32'h00000000);
        xfer("lwfltmis", 1'b0, WORD, 1'b0, 32'hFFFD, 32'h0,
             1'b0, 32'd0, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Initiator side of the data-memory port: accepts one load/store per handshake from the execute stage and drives `dmem_*` toward the byte-addressed data memory.
- Registers load data and returns it to writeback.
- Flags out-of-range accesses.
- Handles misaligned half-word/word accesses, either by splitting them into byte accesses or by trapping.

## Interface
Parameters:
- ADDR_WIDTH, 16, implemented byte-address bits; any accessed byte ≥ 2^ADDR_WIDTH faults

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  LSU can accept; equals (state == IDLE)
- req_wr_en  in  1  1 = store, 0 = load
- req_size  in  mem_size_t  BYTE / HALF_WORD / WORD
- req_zero_extend  in  1  1 = LBU/LHU
- req_addr  in  32  byte address
- req_wr_data  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rd_data  out  32  extended load data; 0 for stores/faults/traps
- rsp_fault  out  1  address out of range
- rsp_misaligned  out  1  misaligned access trapped (macro off only)
- dmem_req, dmem_wr_en, dmem_zero_extend  out  1 each  memory strobes
- dmem_data_size  out  mem_size_t  access size
- dmem_addr  out  32  memory address
- dmem_wr_data  out  32  memory write data
- dmem_rd_data  in  32  combinational read data from memory

## Operation
States:
- IDLE: req_ready = 1.
  - Accept on req_valid && req_ready.
  - Capture addr, size, wr_en, zero_extend and wr_data.
  - Next state is ACCESS, or SPLIT for misaligned accesses with the macro on.
- ACCESS: drive `dmem_*` from the captured registers with dmem_req = 1.
  - Load: sample dmem_rd_data at the closing edge.
  - Store: the memory writes at the same edge.
  - Next state is IDLE; rsp_valid = 1 in the following cycle.
- SPLIT: byte counter i = 0..N-1 (N = 2 for half-word, 4 for word).
  - Each cycle: dmem_req = 1, dmem_data_size = BYTE, dmem_addr = addr + i, dmem_zero_extend = 1.
  - Store: dmem_wr_data[7:0] = wr_data[8i+7:8i].
  - Load: dmem_rd_data[7:0] is written into buffer lane i.
  - After i = N-1: next state is IDLE; rsp_valid in the following cycle, with extension applied per size and zero_extend.

Checks, evaluated at accept on the captured request:
- Fault: addr + bytes − 1 ≥ 2^ADDR_WIDTH, computed in 33 bits so that 32-bit wrap counts as a fault.
  - No dmem_req is issued.
  - Next state is ACCESS with dmem_req forced to 0.
  - Response: rsp_fault = 1, rsp_rd_data = 0.
  - Fault has priority over misalignment.
- Misaligned: half-word with addr[0] = 1, or word with addr[1:0] ≠ 0.

Outputs outside ACCESS/SPLIT: all `dmem_*` outputs are 0.

rsp_fault, rsp_misaligned and rsp_rd_data:
- Registered.
- Valid only while rsp_valid = 1.
- Held at 0 otherwise.

## Timing
- Aligned access accepted at edge 0: dmem_req during cycle 1, rsp_valid during cycle 2.
- req_ready is high again in cycle 2, so back-to-back aligned throughput is 1 access per 2 cycles.
- Split access: N dmem_req cycles, then rsp_valid. Latency is N + 1 cycles after accept.
- rsp_valid has no backpressure; the consumer must take it.
- Reset values:
  - state = IDLE, so req_ready = 1.
  - rsp_valid = rsp_fault = rsp_misaligned = 0, rsp_rd_data = 0.
  - All `dmem_*` outputs = 0.
- Reset mid-operation: the access is aborted and no rsp_valid is produced. Bytes already stored by earlier SPLIT cycles remain written.
- req_valid while not ready is ignored; the requester holds it.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined:
  - Misaligned accesses use SPLIT.
  - rsp_misaligned is tied to 0.
- LSU_MISALIGN_SPLIT_EN undefined:
  - SPLIT state and byte counter are absent.
  - A misaligned access goes to ACCESS with dmem_req = 0.
  - Response two cycles after accept: rsp_misaligned = 1, rsp_rd_data = 0.

## Structure
- risc_pkg (existing) provides mem_size_t.
- risc_pkg gains:
  - lsu_state_t enum {IDLE, ACCESS, SPLIT}.
  - A size-to-byte-count function returning 1/2/4.
- One sub-module: lsu_load_extend.
  - Combinational sign/zero extension of the raw assembled bytes per size and zero_extend.
  - Shared by the aligned and split paths.

## Test plan
- Store WORD 0xDEADBEEF @0x0100, then load WORD @0x0100 → dmem_req for one cycle each; rsp_rd_data = 0xDEADBEEF two cycles after each accept.
- Load BYTE @0x0100 with zero_extend = 0 → 0xFFFFFFEF; with zero_extend = 1 → 0x000000EF.
- Load WORD @0xFFFE with ADDR_WIDTH = 16 → no dmem_req; rsp_fault = 1, rsp_rd_data = 0.
- Macro on: store WORD 0x11223344 @0x0201, then load HALF_WORD @0x0203 with sign extension.
  - Store: four byte accesses to 0x0201..0x0204 with data 44, 33, 22, 11.
  - Load: rsp_rd_data = 0x00001122, rsp_valid 3 cycles after accept.
- Macro off: load HALF_WORD @0x0101 → no dmem_req; rsp_misaligned = 1 two cycles after accept.
- Macro on: assert rst during the 2nd SPLIT cycle of a word store → all outputs 0 immediately, no rsp_valid, req_ready = 1, first byte present in memory.
